// File: rtl/fixed_act_pkg.sv
// Shared fixed-point helpers for the activation operators: derived widths,
// saturation bounds and round-half-up/saturate arithmetic on a wide signed accumulator.
package fixed_act_pkg;

  localparam int ACC_W = 64;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam int DEF_IN_W    = 8;
  localparam int DEF_IN_F    = 4;
  localparam int DEF_SLOPE_W = 8;
  localparam int DEF_SLOPE_F = 7;
  localparam int DEF_OUT_W   = 8;
  localparam int DEF_OUT_F   = 4;
  localparam int PROD_W      = DEF_IN_W + DEF_SLOPE_W;
  localparam int SHIFT       = DEF_IN_F + DEF_SLOPE_F - DEF_OUT_F;
  localparam int DEF_OUT_MAX = (1 << (DEF_OUT_W - 1)) - 1;
  localparam int DEF_OUT_MIN = -(1 << (DEF_OUT_W - 1));

  function automatic int prod_width(int in_w, int slope_w);
    return in_w + slope_w;
  endfunction

  function automatic int shift_amount(int in_f, int slope_f, int out_f);
    return in_f + slope_f - out_f;
  endfunction

  function automatic acc_t sat_max(int out_w);
    return (acc_t'(1) <<< (out_w - 1)) - acc_t'(1);
  endfunction

  function automatic acc_t sat_min(int out_w);
    return -(acc_t'(1) <<< (out_w - 1));
  endfunction

  // The accumulator is far wider than any product, so the rounding add cannot overflow.
  function automatic acc_t round_half_up(acc_t p, int sh);
    if (sh > 0) return (p + (acc_t'(1) <<< (sh - 1))) >>> sh;
    else        return p;
  endfunction

  function automatic acc_t saturate(acc_t r, int out_w);
    if (r > sat_max(out_w))      return sat_max(out_w);
    else if (r < sat_min(out_w)) return sat_min(out_w);
    else                         return r;
  endfunction

  function automatic acc_t round_sat(acc_t p, int sh, int out_w);
    return saturate(round_half_up(p, sh), out_w);
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational per-lane conversion of a full-precision product to the output
// format with round-half-up and saturation; flags lanes that clamped.
module fixed_round_sat
  import fixed_act_pkg::*;
#(
  parameter int PROD_W = 16,
  parameter int SHIFT  = 7,
  parameter int OUT_W  = 8
) (
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [OUT_W-1:0]  res,
  output logic                     sat
);

  acc_t r_full;
  acc_t r_sat;

  // Saturation is detected by comparing the rounded value before and after clamping.
  always_comb begin
    r_full = round_half_up(acc_t'(prod), SHIFT);
    r_sat  = round_sat(acc_t'(prod), SHIFT, OUT_W);
    sat    = (r_full != r_sat);
    res    = r_sat[OUT_W-1:0];
  end

endmodule

// File: rtl/fixed_leaky_relu_pipe.sv
// Two-stage handshaked leaky ReLU with a programmable fixed-point slope:
// S1 forms the per-lane product, S2 rounds, saturates and presents the result.
module fixed_leaky_relu_pipe
  import fixed_act_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int SLOPE_PRECISION_0           = 8,
  parameter int SLOPE_PRECISION_1           = 7,
  parameter int SLOPE_RESET                 = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [SLOPE_PRECISION_0-1:0]           slope_in,
  input  logic                                   slope_we,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0][DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                                   data_in_0_valid,
  output logic                                   data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0][DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                                   data_out_0_valid,
  input  logic                                   data_out_0_ready,
  output logic                                   sat_flag
);

  localparam int N       = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int IN_W    = DATA_IN_0_PRECISION_0;
  localparam int SLOPE_W = SLOPE_PRECISION_0;
  localparam int SLOPE_F = SLOPE_PRECISION_1;
  localparam int OUT_W   = DATA_OUT_0_PRECISION_0;
  localparam int P_W     = prod_width(IN_W, SLOPE_W);
  localparam int SH      = shift_amount(DATA_IN_0_PRECISION_1, SLOPE_F, DATA_OUT_0_PRECISION_1);

  logic signed [SLOPE_W-1:0] slope_q;
  logic                      v1, v2;
  logic                      ready1, ready2;
  logic signed [P_W-1:0]     prod_d [N];
  logic signed [P_W-1:0]     prod_q [N];
  logic signed [OUT_W-1:0]   lane_res [N];
  logic [N-1:0]              lane_sat;

  assign ready2           = !v2 || data_out_0_ready;
  assign ready1           = !v1 || ready2;
  assign data_in_0_ready  = rst || ready1;
  assign data_out_0_valid = v2;

  always_ff @(posedge clk) begin
    if (rst)           slope_q <= SLOPE_W'(SLOPE_RESET);
    else if (slope_we) slope_q <= slope_in;
  end

  // Positive inputs are only realigned to the product's fractional point.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (data_in_0[i][IN_W-1])
        prod_d[i] = P_W'($signed(data_in_0[i])) * P_W'(slope_q);
      else
        prod_d[i] = P_W'($signed(data_in_0[i])) <<< SLOPE_F;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         v1 <= 1'b0;
    else if (ready1) v1 <= data_in_0_valid;
  end

  always_ff @(posedge clk) begin
    if (ready1 && data_in_0_valid) prod_q <= prod_d;
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    fixed_round_sat #(
      .PROD_W (P_W),
      .SHIFT  (SH),
      .OUT_W  (OUT_W)
    ) u_round_sat (
      .prod (prod_q[g]),
      .res  (lane_res[g]),
      .sat  (lane_sat[g])
    );
  end

  // S2 only changes when it can advance, which holds the output under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2         <= 1'b0;
      data_out_0 <= '0;
      sat_flag   <= 1'b0;
    end else if (ready2) begin
      v2 <= v1;
      if (v1) begin
        for (int i = 0; i < N; i++) data_out_0[i] <= lane_res[i];
        if (|lane_sat) sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fixed_leaky_relu_pipe.sv
// Scoreboard bench for fixed_leaky_relu_pipe: accepted beats push expected results
// from a real-arithmetic model, and an output monitor pops and compares them.
module tb_fixed_leaky_relu_pipe;

  localparam int IN_W      = 8;
  localparam int IN_F      = 4;
  localparam int OUT_W     = 8;
  localparam int OUT_F     = 4;
  localparam int SLOPE_W   = 8;
  localparam int SLOPE_F   = 7;
  localparam int D0        = 1;
  localparam int D1        = 1;
  localparam int N         = D0 * D1;
  localparam int SHIFT_AMT = IN_F + SLOPE_F - OUT_F;
  localparam int OUT_MAX   = (1 << (OUT_W - 1)) - 1;
  localparam int OUT_MIN   = -(1 << (OUT_W - 1));

  logic                        clk = 1'b0;
  logic                        rst;
  logic [SLOPE_W-1:0]          slope_in;
  logic                        slope_we;
  logic [N-1:0][IN_W-1:0]      data_in_0;
  logic                        data_in_0_valid;
  logic                        data_in_0_ready;
  logic [N-1:0][OUT_W-1:0]     data_out_0;
  logic                        data_out_0_valid;
  logic                        data_out_0_ready;
  logic                        sat_flag;

  typedef struct {
    logic [N-1:0][OUT_W-1:0] data;
    bit                      sat;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   model_slope;
  bit   model_sat;

  always #5 clk = ~clk;

  fixed_leaky_relu_pipe #(
    .DATA_IN_0_PRECISION_0       (IN_W),
    .DATA_IN_0_PRECISION_1       (IN_F),
    .DATA_IN_0_PARALLELISM_DIM_0 (D0),
    .DATA_IN_0_PARALLELISM_DIM_1 (D1),
    .DATA_OUT_0_PRECISION_0      (OUT_W),
    .DATA_OUT_0_PRECISION_1      (OUT_F),
    .SLOPE_PRECISION_0           (SLOPE_W),
    .SLOPE_PRECISION_1           (SLOPE_F),
    .SLOPE_RESET                 (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .slope_in         (slope_in),
    .slope_we         (slope_we),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .data_out_0       (data_out_0),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready),
    .sat_flag         (sat_flag)
  );

  // Real-valued leaky ReLU rescaled to output LSBs, rounded half up, then clamped.
  function automatic int ref_lane(input int x, input int s, output bit sat);
    longint p;
    int     y;
    p   = (x < 0) ? longint'(x) * s : longint'(x) * (1 << SLOPE_F);
    y   = int'($floor(real'(p) / real'(1 << SHIFT_AMT) + 0.5));
    sat = 1'b0;
    if (y > OUT_MAX)      begin y = OUT_MAX; sat = 1'b1; end
    else if (y < OUT_MIN) begin y = OUT_MIN; sat = 1'b1; end
    return y;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint required);
    tests++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, required);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setLanes(input int x);
    for (int i = 0; i < N; i++) data_in_0[i] = IN_W'(x);
  endtask

  task automatic applyStimulus(input int x, input bit we, input int sv);
    bit accepted;
    setLanes(x);
    data_in_0_valid = 1'b1;
    slope_we        = we;
    slope_in        = SLOPE_W'(sv);
    accepted        = 1'b0;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(posedge clk);
      accepted = data_in_0_ready;
      #1;
    end
    slope_we = 1'b0;
    if (!accepted) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: actual no accept, required accept within 50 cycles");
    end
  endtask

  task automatic idle();
    data_in_0_valid = 1'b0;
    slope_we        = 1'b0;
  endtask

  task automatic writeSlope(input int v);
    slope_we = 1'b1;
    slope_in = SLOPE_W'(v);
    tick();
    slope_we = 1'b0;
  endtask

  task automatic drainWait(input string name);
    int c = 0;
    data_out_0_ready = 1'b1;
    while (q.size() != 0 && c < 200) begin
      tick();
      c++;
    end
    repeat (3) tick();
    checkOutput(name, q.size(), 0);
  endtask

  // Every beat accepted outside reset pushes its expected result with the slope in effect.
  task automatic inputWatcher();
    exp_t e;
    bit   ls;
    int   y;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        model_slope = 32;
      end else begin
        if (data_in_0_valid && data_in_0_ready) begin
          e.sat = 1'b0;
          for (int i = 0; i < N; i++) begin
            y         = ref_lane(int'($signed(data_in_0[i])), model_slope, ls);
            e.data[i] = y[OUT_W-1:0];
            e.sat     = e.sat | ls;
          end
          q.push_back(e);
        end
        if (slope_we) model_slope = int'($signed(slope_in));
      end
    end
  endtask

  task automatic outputMonitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_sat = 1'b0;
      end else if (data_out_0_valid && data_out_0_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_beat: actual 0x%0h, required no beat", data_out_0);
        end else begin
          e         = q.pop_front();
          model_sat = model_sat | e.sat;
          checkOutput("data_out", data_out_0, e.data);
          checkOutput("sat_flag", sat_flag, model_sat);
        end
      end
    end
  endtask

  initial begin
    int                      bp_x [4];
    int                      k;
    int                      cnt;
    int                      y;
    bit                      ls;
    logic [N-1:0][OUT_W-1:0] exp0;

    rst              = 1'b1;
    slope_in         = '0;
    slope_we         = 1'b0;
    data_in_0        = '0;
    data_in_0_valid  = 1'b0;
    data_out_0_ready = 1'b1;
    model_slope      = 32;
    model_sat        = 1'b0;

    fork
      inputWatcher();
      outputMonitor();
    join_none

    tick();
    @(negedge clk);
    checkOutput("reset_in_ready", data_in_0_ready, 1);
    checkOutput("reset_out_valid", data_out_0_valid, 0);
    checkOutput("reset_out_data", data_out_0, 0);
    checkOutput("reset_sat", sat_flag, 0);
    tick();
    rst = 1'b0;

    // Default slope 0.25: latency and the basic transfer points.
    applyStimulus(-16, 1'b0, 0);
    idle();
    @(negedge clk);
    checkOutput("latency_cycle1_valid", data_out_0_valid, 0);
    @(negedge clk);
    checkOutput("latency_cycle2_valid", data_out_0_valid, 1);
    tick();
    applyStimulus(127, 1'b0, 0);
    applyStimulus(0, 1'b0, 0);
    applyStimulus(-1, 1'b0, 0);
    applyStimulus(-3, 1'b0, 0);
    applyStimulus(-2, 1'b0, 0);
    idle();
    drainWait("drain_basic");
    checkOutput("sat_after_rounding", sat_flag, 0);

    // Slope -1.0 makes -128 overflow the positive range.
    writeSlope(-128);
    applyStimulus(-128, 1'b0, 0);
    applyStimulus(-16, 1'b0, 0);
    applyStimulus(50, 1'b0, 0);
    idle();
    drainWait("drain_sat");
    checkOutput("sat_sticky", sat_flag, 1);
    writeSlope(32);

    // Backpressure: downstream stalls for six edges while four beats are offered.
    bp_x[0] = -16; bp_x[1] = 40; bp_x[2] = -80; bp_x[3] = 100;
    y = ref_lane(bp_x[0], 32, ls);
    for (int i = 0; i < N; i++) exp0[i] = y[OUT_W-1:0];
    data_out_0_ready = 1'b0;
    k = 0;
    setLanes(bp_x[0]);
    data_in_0_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      if (data_in_0_valid && data_in_0_ready) k++;
      #1;
      if (k < 4) setLanes(bp_x[k]);
      else data_in_0_valid = 1'b0;
      if (c == 5) begin
        checkOutput("stall_accepts", k, 2);
        checkOutput("stall_in_ready", data_in_0_ready, 0);
        data_out_0_ready = 1'b1;
      end
      @(negedge clk);
      if (data_out_0_valid) checkOutput("stall_hold", data_out_0, exp0);
    end
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      if (data_in_0_valid && data_in_0_ready) k++;
      #1;
      if (k < 4) setLanes(bp_x[k]);
      else data_in_0_valid = 1'b0;
      @(negedge clk);
      if (data_out_0_valid) cnt++;
    end
    idle();
    checkOutput("release_accepts", k, 4);
    checkOutput("release_no_gaps", cnt, 3);
    drainWait("drain_backpressure");

    // Slope written while B is accepted affects only C.
    applyStimulus(-16, 1'b0, 0);
    applyStimulus(-16, 1'b1, 64);
    applyStimulus(-16, 1'b0, 0);
    idle();
    drainWait("drain_slope_change");

    // Reset with two beats in flight discards them and restores defaults.
    writeSlope(-128);
    applyStimulus(-128, 1'b0, 0);
    idle();
    drainWait("drain_pre_reset");
    data_out_0_ready = 1'b0;
    applyStimulus(-16, 1'b0, 0);
    applyStimulus(-32, 1'b0, 0);
    idle();
    checkOutput("inflight_valid", data_out_0_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_valid", data_out_0_valid, 0);
    checkOutput("post_reset_sat", sat_flag, 0);
    checkOutput("post_reset_data", data_out_0, 0);
    tick();
    data_out_0_ready = 1'b1;
    repeat (5) tick();
    applyStimulus(-16, 1'b0, 0);
    idle();
    drainWait("drain_post_reset");

    // Randomised traffic with random backpressure and occasional slope writes.
    for (int c = 0; c < 400; c++) begin
      data_in_0_valid  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) data_in_0[i] = IN_W'($urandom);
      slope_we         = ($urandom_range(0, 15) == 0);
      slope_in         = SLOPE_W'($urandom);
      data_out_0_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle();
    drainWait("drain_random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fixed_leaky_relu_pipe.md
Name: fixed_leaky_relu_pipe

Overview:
- Pipelined, fully handshaked leaky-ReLU (PReLU-capable) for the activations library.
- Supports a runtime-programmable signed fixed-point negative slope and independent input and output fixed-point formats.
- Output conversion uses round-half-up and saturation.
- Sits between a linear/conv stream producer and the next streaming operator. Accepts one parallel beat per cycle under full backpressure.

Parameters:
- DATA_IN_0_PRECISION_0, 8: input word width (signed).
- DATA_IN_0_PRECISION_1, 4: input fractional bits.
- DATA_IN_0_PARALLELISM_DIM_0, 1: lanes, dim 0.
- DATA_IN_0_PARALLELISM_DIM_1, 1: lanes, dim 1. Lane count N = DIM_0*DIM_1.
- DATA_OUT_0_PRECISION_0, 8: output word width (signed).
- DATA_OUT_0_PRECISION_1, 4: output fractional bits. Requires IN_F + SLOPE_F >= OUT_F.
- SLOPE_PRECISION_0, 8: slope width (signed).
- SLOPE_PRECISION_1, 7: slope fractional bits.
- SLOPE_RESET, 32: slope register value after reset (0.25 at default format).

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- slope_in, input, SLOPE_PRECISION_0: new slope value.
- slope_we, input, 1: slope write strobe.
- data_in_0, input, N x DATA_IN_0_PRECISION_0: input lanes.
- data_in_0_valid, input, 1: input beat valid.
- data_in_0_ready, output, 1: input beat accepted when high together with valid.
- data_out_0, output, N x DATA_OUT_0_PRECISION_0: result lanes.
- data_out_0_valid, output, 1: output beat valid.
- data_out_0_ready, input, 1: downstream accepts.
- sat_flag, output, 1: sticky, set when any lane saturated.

Behaviour:
- Reset (rst high at a clk edge):
  - All stage valids clear, so data_out_0_valid = 0.
  - data_out_0 = 0; sat_flag = 0; slope register = SLOPE_RESET.
  - data_in_0_ready is combinational and equals 1 during reset.
  - Reset mid-stream discards all in-flight beats; no partial beat emerges.
- Slope register:
  - Loads slope_in on a clk edge with slope_we = 1 (ignored while rst).
  - Each beat captures the slope in effect on its acceptance cycle and carries it down the pipe.
  - A write in the same cycle as an accepted beat does not apply to that beat; it applies from the next accepted beat onward. In-flight beats are never affected.
- Pipeline, two register stages:
  - S1 captures the input lanes, computes each lane's product, and stores it.
  - S2 applies rounding and saturation and drives data_out_0.
  - Latency is 2 cycles from acceptance to data_out_0_valid when unstalled.
  - Throughput is 1 beat/cycle.
- Handshake:
  - ready_k = !valid_k || ready_{k+1}, with ready_3 = data_out_0_ready; data_in_0_ready = ready_1.
  - Capacity is 2 beats. No beat is dropped or duplicated, and order is preserved.
  - data_out_0 is stable while data_out_0_valid && !data_out_0_ready.
  - Simultaneous accept-in and accept-out while full is legal; the pipe advances.
- Arithmetic, per lane, with x signed IN_W/IN_F and s signed SLOPE_W/SLOPE_F:
  - If x < 0: p = x*s. Otherwise p = x << SLOPE_F. x = 0 gives 0.
  - p has width IN_W + SLOPE_W and IN_F + SLOPE_F fractional bits.
  - Let sh = IN_F + SLOPE_F - OUT_F. If sh > 0: r = (p + 2^(sh-1)) >>> sh, with the adder one bit wider so it never overflows. If sh = 0: r = p.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- sat_flag:
  - Sets on the cycle S2 is loaded with a beat in which any lane clamped.
  - Stays set until rst.

Decomposition:
- Package fixed_act_pkg:
  - Derived widths: PROD_W = IN_W + SLOPE_W, SHIFT = IN_F + SLOPE_F - OUT_F.
  - Saturation bound constants.
  - A function for round-half-up with saturate.
- One sub-module, fixed_round_sat: a combinational per-lane round/saturate, instantiated N times in S2.
- The handshake logic stays inline (two valid bits).

Test Plan:
- Defaults, slope 32 (0.25); x = -16 (-1.0) -> out -4. x = 127 -> 127. x = 0 -> 0. Latency is exactly 2 cycles.
- Rounding, slope 32: x = -1 -> 0. x = -3 -> -1. x = -2 -> 0. sat_flag stays 0.
- Saturation: write slope -128 (-1.0), then x = -128 -> 127 and sat_flag = 1. The flag persists after further normal beats and clears only on rst.
- Backpressure: data_out_0_ready = 0 for 6 cycles while 4 beats are offered.
  - data_in_0_ready must fall after 2 accepts.
  - data_out_0 must be held stable.
  - After release, all 4 beats emerge in order with no gaps under continuous ready.
- Slope change mid-stream: beats A, B, C accepted on consecutive cycles (x = -16 each), with slope_we = 1 and slope_in = 64 in the cycle B is accepted. Outputs must be A -> -4, B -> -4, C -> -8.
- Reset mid-operation: with 2 beats in flight, assert rst for 1 cycle. Then data_out_0_valid = 0, the slope returns to 32, sat_flag = 0, and no stale beat appears afterwards.
